// File: rtl/decimal_to_bin_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM states and defaults.
package decimal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DIGIT_MAX  = 9;
  localparam int DEF_DIGITS = 2;
  localparam int DEF_BIN_W  = 7;

endpackage

// File: rtl/decimal_to_bin_if.sv
// Request/response bundle between digit entry and the converter.
interface decimal_to_bin_if
  import decimal_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
);
  logic                  start_i;
  logic [4*DIGITS-1:0]   bcd_i;
  logic                  busy_o;
  logic                  valid_o;
  logic [BIN_W-1:0]      bin_o;
  logic                  err_o;

  modport master (output start_i, bcd_i, input busy_o, valid_o, bin_o, err_o);
  modport slave  (input start_i, bcd_i, output busy_o, valid_o, bin_o, err_o);
endinterface

// File: rtl/decimal_to_bin_nibble_adjust.sv
// Reverse double-dabble correction for one BCD digit after a right shift.
module bcd_nibble_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd8) ? din - 4'd3 : din;
endmodule

// File: rtl/decimal_to_bin.sv
// Sequential BCD-to-binary converter: one reverse double-dabble step per clock.
module decimal_to_bin
  import decimal_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  decimal_to_bin_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               busy_q, valid_q, err_o_q;
  logic [BIN_W-1:0]   bin_o_q;

  logic               bad_digit;
  logic [SH_W-1:0]    sh;
  logic [BCD_W-1:0]   bcd_sh, bcd_adj;

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (bus.bcd_i[4*d +: 4] > 4'(DIGIT_MAX)) bad_digit = 1'b1;
  end

  // Digits shift down into the binary register; each digit is then re-biased.
  assign sh     = {bcd_q, bin_q} >> 1;
  assign bcd_sh = sh[SH_W-1:BIN_W];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .din  (bcd_sh[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start_i) state_d = bad_digit ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      bin_o_q <= '0;
      err_o_q <= 1'b0;
    end else begin
      busy_q  <= (state_d != ST_IDLE);
      valid_q <= (state_q == ST_DONE);
      unique case (state_q)
        ST_IDLE: if (bus.start_i) begin
          bcd_q <= bus.bcd_i;
          bin_q <= '0;
          cnt_q <= '0;
          err_q <= bad_digit;
        end
        ST_SHIFT: begin
          bcd_q <= bcd_adj;
          bin_q <= sh[BIN_W-1:0];
          cnt_q <= cnt_q + 1'b1;
        end
        ST_DONE: begin
          bin_o_q <= bin_q;
          err_o_q <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.bin_o   = bin_o_q;
  assign bus.err_o   = err_o_q;

endmodule

// File: tb/tb_decimal_to_bin.sv
// Directed bench for decimal_to_bin: reset, values, illegal digits, busy, back-to-back, sweep.
module tb_decimal_to_bin;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decimal_to_bin_if #(.DIGITS(2), .BIN_W(7)) bus ();

  decimal_to_bin #(.DIGITS(2), .BIN_W(7)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge; lat = edges after the accepting edge until valid.
  task automatic conv(input logic [7:0] b, output int lat, output logic [6:0] bin,
                      output logic err, output bit held);
    logic [6:0] b0;
    logic       e0;
    b0 = bus.bin_o;
    e0 = bus.err_o;
    lat = -1;
    held = 1'b1;
    bus.start_i = 1'b1;
    bus.bcd_i   = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start_i = 1'b0;
        bus.bcd_i   = 8'($urandom);
      end
      if (bus.valid_o) begin
        lat = i;
        break;
      end
      if (bus.bin_o !== b0 || bus.err_o !== e0) held = 1'b0;
    end
    bin = bus.bin_o;
    err = bus.err_o;
  endtask

  logic [7:0] dv [6] = '{8'h00, 8'h05, 8'h15, 8'h42, 8'h73, 8'h99};
  int         de [6] = '{0, 5, 15, 42, 73, 99};

  initial begin
    int         lat, vcnt, bcnt, vlat, npulse, last, first;
    logic [6:0] bin, got;
    logic       err;
    bit         held;

    bus.start_i = 1'b0;
    bus.bcd_i   = '0;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy",  bus.busy_o,  0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_bin",   bus.bin_o,   0);
    check("rst_err",   bus.err_o,   0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values
    for (int k = 0; k < 6; k++) begin
      conv(dv[k], lat, bin, err, held);
      check($sformatf("dir_lat_%0h", dv[k]), lat, 8);
      check($sformatf("dir_bin_%0h", dv[k]), bin, de[k]);
      check($sformatf("dir_err_%0h", dv[k]), err, 0);
    end

    // Illegal digit, then recovery
    conv(8'h4A, lat, bin, err, held);
    check("ill_lat", lat, 1);
    check("ill_err", err, 1);
    check("ill_bin", bin, 0);
    conv(8'h12, lat, bin, err, held);
    check("rec_lat", lat, 8);
    check("rec_err", err, 0);
    check("rec_bin", bin, 12);

    // Reset mid-SHIFT discards the in-flight request
    bus.start_i = 1'b1;
    bus.bcd_i   = 8'h42;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  bus.busy_o,  0);
    check("mid_rst_valid", bus.valid_o, 0);
    check("mid_rst_bin",   bus.bin_o,   0);
    check("mid_rst_err",   bus.err_o,   0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.valid_o) vcnt++;
      if (bus.busy_o)  bcnt++;
    end
    check("post_rst_valid_cnt", vcnt, 0);
    check("post_rst_busy_cnt",  bcnt, 0);

    // Start during SHIFT is ignored
    bus.start_i = 1'b1;
    bus.bcd_i   = 8'h37;
    vcnt = 0; bcnt = 0; vlat = -1; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.start_i = 1'b0;
      if (i == 3) begin bus.start_i = 1'b1; bus.bcd_i = 8'h81; end
      if (i == 4) bus.start_i = 1'b0;
      if (bus.busy_o) bcnt++;
      if (bus.valid_o) begin vcnt++; got = bus.bin_o; vlat = i; end
    end
    check("busy_valid_cnt", vcnt, 1);
    check("busy_cycles",    bcnt, 8);
    check("busy_bin",       got,  37);
    check("busy_lat",       vlat, 8);

    // Back-to-back with start held high
    bus.start_i = 1'b1;
    bus.bcd_i   = 8'h64;
    npulse = 0; last = -1; first = -1;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        npulse++;
        check($sformatf("b2b_bin_%0d", npulse), bus.bin_o, 64);
        if (last >= 0) check($sformatf("b2b_gap_%0d", npulse), i - last, 9);
        else first = i;
        last = i;
      end
    end
    bus.start_i = 1'b0;
    check("b2b_pulses", npulse, 3);
    check("b2b_first",  first,  8);
    repeat (3) @(negedge clk);

    // Sweep of every legal value against the decimal weighting
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        conv({4'(t), 4'(o)}, lat, bin, err, held);
        check($sformatf("sw_bin_%0d%0d", t, o),  bin,  t * 10 + o);
        check($sformatf("sw_err_%0d%0d", t, o),  err,  0);
        check($sformatf("sw_lat_%0d%0d", t, o),  lat,  8);
        check($sformatf("sw_hold_%0d%0d", t, o), held, 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
